// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: imem req/ack port, decode-side stall, execute-side
// redirect and the IF/ID output register. master = if_stage, slave = environment.
interface if_stage_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [XLEN-1:0] ins_o;
  logic [XLEN-1:0] pc_o;
  logic            valid_o;
  logic            misalign_o;

  modport master (
    output imem_req_o, imem_addr_o, ins_o, pc_o, valid_o, misalign_o,
    input  imem_ack_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, ins_o, pc_o, valid_o, misalign_o,
    output imem_ack_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch stage: PC, imem req/ack fetch, IF/ID register, stall and redirect.
// Optional macro IF_MISALIGN_CHECK_EN: misaligned redirect sets sticky misalign_o and halts.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
`ifdef IF_MISALIGN_CHECK_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  state_t          resume_state;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] hbuf_ins_q, hbuf_ins_d;
  logic [XLEN-1:0] hbuf_pc_q, hbuf_pc_d;
  logic [XLEN-1:0] ins_q, ins_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] redir_pc;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic redir_bad;

  assign redir_pc  = bus.redirect_pc_i;
  assign redir_bad = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
  assign misalign_d = misalign_q | redir_bad;
  // Once the flag is set every exit from a transaction lands in HALT.
  assign resume_state = misalign_d ? S_HALT : S_FETCH;
  assign bus.misalign_o = misalign_q;
`else
  logic unused_redir_lsb;

  assign redir_pc         = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redir_lsb = ^bus.redirect_pc_i[1:0];
  assign resume_state     = S_FETCH;
  assign bus.misalign_o   = 1'b0;
`endif

  // Request is a pure function of state so the address stays put until ack.
  assign bus.imem_req_o  = ((state_q == S_FETCH) || (state_q == S_DRAIN)) && !rst;
  assign bus.imem_addr_o = fetch_pc_q;
  assign bus.ins_o       = ins_q;
  assign bus.pc_o        = pc_q;
  assign bus.valid_o     = valid_q;

  // Next-state and next-register logic.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    hbuf_ins_d = hbuf_ins_q;
    hbuf_pc_d  = hbuf_pc_q;
    ins_d      = ins_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    if (bus.redirect_i) begin
      ins_d      = '0;
      pc_d       = '0;
      valid_d    = 1'b0;
      hbuf_ins_d = '0;
      hbuf_pc_d  = '0;
    end

    case (state_q)
      S_FETCH: begin
        if (bus.redirect_i) begin
          if (bus.imem_ack_i) begin
            fetch_pc_d = redir_pc;
            state_d    = resume_state;
          end else begin
            target_d = redir_pc;
            state_d  = S_DRAIN;
          end
        end else if (bus.imem_ack_i) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          if (bus.stall_i && valid_q) begin
            hbuf_ins_d = bus.imem_rdata_i;
            hbuf_pc_d  = fetch_pc_q;
            state_d    = S_HOLD;
          end else begin
            ins_d   = bus.imem_rdata_i;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
          end
        end else if (!bus.stall_i) begin
          ins_d   = '0;
          pc_d    = '0;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (bus.redirect_i) begin
          fetch_pc_d = redir_pc;
          state_d    = resume_state;
        end else if (!bus.stall_i) begin
          ins_d   = hbuf_ins_q;
          pc_d    = hbuf_pc_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        ins_d   = '0;
        pc_d    = '0;
        valid_d = 1'b0;
        if (bus.redirect_i) begin
          target_d = redir_pc;
        end
        if (bus.imem_ack_i) begin
          fetch_pc_d = bus.redirect_i ? redir_pc : target_q;
          state_d    = resume_state;
        end
      end

      default: begin
        ins_d   = '0;
        pc_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      target_q   <= '0;
      hbuf_ins_q <= '0;
      hbuf_pc_q  <= '0;
      ins_q      <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      hbuf_ins_q <= hbuf_ins_d;
      hbuf_pc_q  <= hbuf_pc_d;
      ins_q      <= ins_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage of the five-stage RV32I pipeline. It holds the program counter and issues word fetches to instruction memory over a req/ack handshake. It writes each returned instruction and its PC into the IF/ID output register, which `id_stage` decodes. It also absorbs decode-side stalls and execute-side redirects (jumps and taken branches), discarding any fetch that is in flight when a redirect arrives.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `imem_req_o`, out, 1: fetch request. Held high with `imem_addr_o` stable until ack.
- `imem_addr_o`, out, 32: word-aligned fetch address.
- `imem_ack_i`, in, 1: single-cycle acknowledge. May arrive in the same cycle as req (zero-wait) or any later cycle.
- `imem_rdata_i`, in, 32: instruction word, valid only when `imem_ack_i`=1.
- `stall_i`, in, 1: hold the IF/ID register (decode cannot accept).
- `redirect_i`, in, 1: flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i`, in, 32: redirect target.
- `ins_o`, out, 32: instruction to decode. 32'h0 when not valid, which decodes as `OP_INVALID`, an all-zero control bubble.
- `pc_o`, out, 32: PC of `ins_o`.
- `valid_o`, out, 1: `ins_o`/`pc_o` hold a real instruction.
- `misalign_o`, out, 1: sticky misaligned-redirect flag. See Configuration.

## Operation
- Registers:
  - `fetch_pc` drives `imem_addr_o`.
  - `target_q` is the pending redirect target.
  - The hold buffer is `hbuf_ins`/`hbuf_pc`.
  - The output register holds `ins_o`/`pc_o`/`valid_o`.
- `imem_req_o` = (state is FETCH or DRAIN) and not `rst`.
- States:
  - FETCH: request outstanding at `fetch_pc`.
    - On ack with (`!stall_i` or `!valid_o`): load the output register with {rdata, `fetch_pc`, 1} and set `fetch_pc` += 4. Stay in FETCH.
    - On ack with `stall_i && valid_o`: capture {rdata, `fetch_pc`} into the hold buffer, set `fetch_pc` += 4, go to HOLD.
    - With no ack: if `!stall_i`, clear the output register (bubble). If `stall_i`, the output register holds.
  - HOLD: no request. When `!stall_i`, move the hold buffer into the output register and go to FETCH.
  - DRAIN: the request at the old `fetch_pc` is still outstanding. On ack, discard the data, set `fetch_pc` = `target_q`, go to FETCH. The output stays a bubble.
  - HALT: present only with the macro. No requests are issued; exit only by reset.
- Redirect takes priority over stall in every state. It clears the output register to {0, 0, 0} and invalidates the hold buffer.
  - In FETCH with no ack in the same cycle: set `target_q` = `redirect_pc_i`, go to DRAIN. The address is not changed mid-transaction.
  - In FETCH with ack in the same cycle: discard the data, set `fetch_pc` = `redirect_pc_i`, stay in FETCH.
  - In HOLD: set `fetch_pc` = `redirect_pc_i`, go to FETCH.
  - In DRAIN: update `target_q` (the latest redirect wins). If ack arrives in the same cycle, go to FETCH at the new target.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 32'h0.

## Timing
- Reset values:
  - State = FETCH, `fetch_pc` = `RESET_PC`, `target_q` = 0, hold buffer empty.
  - `ins_o` = 0, `pc_o` = 0, `valid_o` = 0, `misalign_o` = 0.
  - `imem_req_o` = 0 while `rst` is high, and 1 in the first cycle after deassertion.
- Reset asserted mid-transaction abandons the transaction immediately. The memory is required to tolerate req dropping.
- Latency is 1 cycle from ack to `valid_o`.
- Throughput with zero-wait memory and no stalls is 1 instruction per clock.
- Stall release from HOLD: the buffered instruction is valid on the next edge, and the new request is issued in that same cycle.
- Redirect: the redirect target appears on `imem_addr_o` in the cycle after `redirect_i`, or after the drain ack if a fetch was outstanding. There is at least one bubble after every redirect.

## Configuration
- `IF_MISALIGN_CHECK_EN`:
  - Defined: a redirect whose `redirect_pc_i[1:0]` != 0 sets `misalign_o` (sticky) and moves the block to HALT, draining any outstanding request first. No further valid output is produced until reset.
  - Undefined: `redirect_pc_i[1:0]` is forced to 2'b00, `misalign_o` is tied to 0, and HALT is not built.

## Test plan
- Reset release with `RESET_PC`=0x100 and zero-wait memory -> `imem_addr_o` = 0x100, 0x104, 0x108 on consecutive cycles; `valid_o`=1 from cycle 2, `pc_o` following one cycle behind the address.
- 3-cycle ack latency -> `valid_o` pulses once every 3 cycles, with `ins_o`=0 between pulses.
- `stall_i` held high for 4 cycles while the ack for 0x108 arrives -> `ins_o`/`pc_o` (0x104) hold steady; after release, 0x108 appears on the next edge with nothing lost or duplicated.
- `redirect_i` to 0x200 while a 0x10C fetch waits for ack -> 0x10C data discarded, `valid_o`=0, next request at 0x200, first valid `pc_o`=0x200.
- Redirect in the same cycle as stall and ack -> the redirect wins: output flushed, the acked data dropped, fetch restarts at the target.
- With the macro defined, redirect to 0x202 -> `misalign_o`=1, `imem_req_o` stays 0 after the drain, `valid_o` stays 0 until reset. Without the macro -> fetch proceeds at 0x200.
